life_scan: RTL and testbench
============================

# life_scan

Generation controller and cell-scan stage that sits directly downstream of the life cell columns. It issues the one-cycle `enable` step pulse to every column, snapshots the flattened `alive_col`/`alive_prev_col` buses of all columns, and streams the snapshot one cell at a time over a valid/ready interface for display or host readout. Population and generation counts are reported per frame.

## Interface
- `COLS`, default 4: number of columns in the array.
- `ROWS`, default 4: cells per column.
- `GEN_W`, default 16: generation counter width.

Clock and reset are fixed: one clock, `clk`; `reset` is synchronous and active-high.

- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `alive_array` in COLS*ROWS: bit `[c*ROWS+r]` is `alive_col[r]` of column c.
- `prev_array` in COLS*ROWS: same mapping, from `alive_prev_col`.
- `run` in 1: level; free-running generations.
- `step_req` in 1: single step and scan.
- `show_req` in 1: scan the current state without stepping.
- `enable` out 1: step pulse to all columns.
- `out_valid` out 1: cell record valid.
- `out_ready` in 1: consumer accepts.
- `out_alive` out 1: snapshot alive bit.
- `out_changed` out 1: `alive ^ prev`.
- `out_col` out clog2(COLS): column of the current record.
- `out_row` out clog2(ROWS): row of the current record.
- `out_last` out 1: final cell of the frame.
- `frame_done` out 1: one-cycle pulse at frame end.
- `population` out clog2(COLS*ROWS+1): live cells in the last frame.
- `gen_count` out GEN_W: completed step pulses.
- `busy` out 1: state is not IDLE.

## Operation
- States: IDLE, STEP, SETTLE, CAPTURE, SCAN, DONE.
- **IDLE**
  - Priority: `run` or `step_req` goes to STEP; otherwise `show_req` goes to CAPTURE.
  - `step_req` and `show_req` are sampled only in IDLE. Pulses in any other state are dropped, not queued.
- **STEP**: `enable`=1 for exactly this cycle; `gen_count` increments (wraps from 2^GEN_W−1 to 0); next state is SETTLE.
- **SETTLE**: one cycle, so the cell registers updated at the STEP edge are visible; next state is CAPTURE.
- **CAPTURE**
  - Registers `alive_array`/`prev_array` into the internal snapshot.
  - Clears the population accumulator and sets the cell index to 0.
  - Next state is SCAN.
- **SCAN**
  - Presents the snapshot cell at the current index. Order is column-major: col 0 rows 0..ROWS−1, then col 1, and so on.
  - `out_changed` = snap_alive ^ snap_prev.
  - `out_last`=1 when index = COLS*ROWS−1.
  - On transfer (`out_valid & out_ready`): the accumulator adds `out_alive` and the index advances. The transfer of the last cell goes to DONE.
- **DONE**
  - `population` is loaded from the accumulator, including the last cell; `frame_done`=1.
  - Next state is STEP if `run`=1, else IDLE.
- Live input changes after CAPTURE do not affect the streamed frame.
- Dropping `run` mid-frame: the current frame completes, then the block returns to IDLE.
- All output fields come from registered state and snapshot. There is no combinational path from `alive_array`/`prev_array` to outputs.

## Timing
- **Reset values**: state IDLE; `enable`, `out_valid`, `out_alive`, `out_changed`, `out_last`, `frame_done`, `busy`, `population`, `gen_count`, `out_col`, `out_row` all 0; snapshot cleared.
- **Reset in any state**: next cycle matches the reset values. A partial frame is discarded and no `frame_done` is issued.
- **`step_req` at cycle t (IDLE)**:
  - STEP at t+1: `enable`=1, and `gen_count` shows +1 from t+2.
  - SETTLE at t+2.
  - CAPTURE at t+3 samples the arrays.
  - First `out_valid` at t+4.
- **`show_req` at cycle t**: CAPTURE at t+1, first `out_valid` at t+2. `enable` stays 0 and `gen_count` is unchanged.
- **Streaming with `out_ready` held 1**: one cell per cycle, so a frame occupies COLS*ROWS consecutive valid cycles.
- **DONE**: one cycle after the last transfer.
- **Handshake**:
  - `out_valid` stays high until transfer and never drops mid-frame.
  - While `out_valid & !out_ready`, all `out_*` fields hold stable.
  - `out_ready` may be high while `out_valid`=0 with no effect.
- **Back-to-back with `run`=1**: the period per generation is 1 (STEP) + 1 (SETTLE) + 1 (CAPTURE) + COLS*ROWS (SCAN) + 1 (DONE) cycles, which is 20 for 4×4 with no stalls.

## Test plan
- **Reset**: hold `reset` 2 cycles during SCAN. Next cycle: all outputs 0, `busy`=0; no `frame_done` or `enable` pulse follows.
- **show_req**:
  - Stimulus: 4×4, `alive_array`=16'h0F00, `prev_array`=16'h0000, `out_ready`=1.
  - Response: 16 records; indices 8..11 (col 2, rows 0..3) have `out_alive`=`out_changed`=1 and all others are 0; `out_last` only on col 3 row 3.
  - Then `frame_done` pulses, `population`=4, `gen_count`=0, `enable` is never high.
- **step_req**: `enable` high exactly at t+1, `gen_count`=1. Array changed to 16'h0070 before t+3 → `population`=3. Array changed to 16'hFFFF after CAPTURE → `population` still 3.
- **Backpressure**: `out_ready` alternating 1,0 plus random stalls. Each of the 16 cells is delivered exactly once in order, and fields stay stable during stalls. `step_req` pulsed mid-scan is ignored (`gen_count` unchanged).
- **Free run**: `run`=1 yields an `enable` pulse every 20 cycles with no stalls. Preload `gen_count` to 16'hFFFF via repeated steps; it wraps to 0. Deassert `run` mid-scan: the frame completes, then IDLE with no further `enable`.
- **Priority**: `show_req` and `step_req` high in the same IDLE cycle → STEP path taken (`enable` pulses).

Source files
------------

// File: rtl/life_scan.sv
// life_scan: generation step controller that snapshots the cell array and streams it cell by cell over valid/ready
//   params : COLS, ROWS (array size), GEN_W (generation counter width)
//   inputs : clk, reset (sync, active-high), alive_array/prev_array (bit c*ROWS+r), run, step_req, show_req, out_ready
//   outputs: enable (step pulse), out_valid/out_alive/out_changed/out_col/out_row/out_last (cell record),
//            frame_done, population, gen_count, busy
module life_scan #(
  parameter int COLS = 4,
  parameter int ROWS = 4,
  parameter int GEN_W = 16,
  localparam int N = COLS * ROWS,
  localparam int CW = COLS > 1 ? $clog2(COLS) : 1,
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1,
  localparam int IW = N > 1 ? $clog2(N) : 1,
  localparam int PW = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     alive_array,
  input  logic [N-1:0]     prev_array,
  input  logic             run,
  input  logic             step_req,
  input  logic             show_req,
  output logic             enable,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_alive,
  output logic             out_changed,
  output logic [CW-1:0]    out_col,
  output logic [RW-1:0]    out_row,
  output logic             out_last,
  output logic             frame_done,
  output logic [PW-1:0]    population,
  output logic [GEN_W-1:0] gen_count,
  output logic             busy
);
  typedef enum logic [2:0] {IDLE, STEP, SETTLE, CAPTURE, SCAN, DONE} state_t;
  state_t state, nxt;
  logic [N-1:0] snap_alive, snap_prev;
  logic [IW-1:0] idx;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [PW-1:0] acc;
  logic last, row_end;
  assign last = idx == IW'(N - 1);
  assign row_end = row == RW'(ROWS - 1);
  assign enable = state == STEP;
  assign out_valid = state == SCAN;
  assign frame_done = state == DONE;
  assign busy = state != IDLE;
  assign out_alive = out_valid & snap_alive[idx];
  assign out_changed = out_valid & (snap_alive[idx] ^ snap_prev[idx]);
  assign out_last = out_valid & last;
  assign out_col = col;
  assign out_row = row;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = (run || step_req) ? STEP : show_req ? CAPTURE : IDLE;
      STEP:    nxt = SETTLE;
      SETTLE:  nxt = CAPTURE;
      CAPTURE: nxt = SCAN;
      SCAN:    nxt = (out_ready && last) ? DONE : SCAN;
      DONE:    nxt = run ? STEP : IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      snap_alive <= '0;
      snap_prev <= '0;
      idx <= '0;
      col <= '0;
      row <= '0;
      acc <= '0;
      population <= '0;
      gen_count <= '0;
    end else begin
      state <= nxt;
      if (state == STEP) gen_count <= gen_count + GEN_W'(1);
      if (state == CAPTURE) begin
        snap_alive <= alive_array;
        snap_prev <= prev_array;
        acc <= '0;
        idx <= '0;
        col <= '0;
        row <= '0;
      end
      // index holds on the final cell so it never leaves the snapshot range
      if (state == SCAN && out_ready) begin
        acc <= acc + PW'(out_alive);
        if (!last) begin
          idx <= idx + IW'(1);
          row <= row_end ? '0 : row + RW'(1);
          col <= row_end ? col + CW'(1) : col;
        end
      end
      if (state == DONE) population <= acc;
    end
  end
endmodule

// File: tb/tb_life_scan.sv
// tb_life_scan: scoreboard bench for life_scan (4x4 array, 6-bit generation counter so wrap is reachable)
module tb_life_scan;
  localparam int COLS = 4, ROWS = 4, N = 16, GW = 6;
  logic clk = 0, reset = 1;
  logic [N-1:0] alive_array = '0, prev_array = '0;
  logic run = 0, step_req = 0, show_req = 0, out_ready = 0;
  logic enable, out_valid, out_alive, out_changed, out_last, frame_done, busy;
  logic [1:0] out_col, out_row;
  logic [4:0] population;
  logic [GW-1:0] gen_count;
  logic [6:0] cur, rec_p;
  logic stall_p = 0;
  logic [6:0] exp_q[$], obs_q[$];
  int errors = 0, checks = 0, en_cnt = 0, fd_cnt = 0, hold_viol = 0;
  logic [GW-1:0] gen_exp = '0;

  life_scan #(.COLS(COLS), .ROWS(ROWS), .GEN_W(GW)) dut (
    .clk(clk), .reset(reset), .alive_array(alive_array), .prev_array(prev_array),
    .run(run), .step_req(step_req), .show_req(show_req), .enable(enable),
    .out_valid(out_valid), .out_ready(out_ready), .out_alive(out_alive),
    .out_changed(out_changed), .out_col(out_col), .out_row(out_row), .out_last(out_last),
    .frame_done(frame_done), .population(population), .gen_count(gen_count), .busy(busy)
  );

  always #5 clk = ~clk;
  assign cur = {out_alive, out_changed, out_col, out_row, out_last};

  always @(negedge clk) begin
    if (!reset) begin
      if (enable) en_cnt <= en_cnt + 1;
      if (frame_done) fd_cnt <= fd_cnt + 1;
      if (stall_p && (!out_valid || cur !== rec_p)) hold_viol <= hold_viol + 1;
      if (out_valid && out_ready) obs_q.push_back(cur);
    end
    stall_p <= out_valid && !out_ready && !reset;
    rec_p <= cur;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame();
    logic [1:0] c, r;
    for (int i = 0; i < N; i++) begin
      c = 2'(i / ROWS);
      r = 2'(i % ROWS);
      exp_q.push_back({alive_array[i], alive_array[i] ^ prev_array[i], c, r, i == N - 1});
    end
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int f0 = fd_cnt;
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      ok = fd_cnt != f0;
    end
  endtask

  task automatic test_reset();
    repeat (2) tick();
    reset = 0;
    checks++;
    if ({enable, out_valid, out_alive, out_changed, out_col, out_row, out_last, frame_done, busy, population} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want all zero", {enable, out_valid, out_alive, out_changed, out_col, out_row, out_last, frame_done, busy, population});
    end
    checks++;
    if (gen_count !== '0) begin errors++; $display("FAIL reset_gen: got %0d want 0", gen_count); end
  endtask

  task automatic test_show();
    bit ok;
    logic [6:0] e, o;
    int e0 = en_cnt;
    alive_array = 16'h0F00; prev_array = 16'h0000; out_ready = 1;
    push_frame();
    show_req = 1;
    tick();
    show_req = 0;
    checks++;
    if (busy !== 1 || out_valid !== 0) begin errors++; $display("FAIL show_capture: busy=%b valid=%b want 1 0", busy, out_valid); end
    tick();
    checks++;
    if (out_valid !== 1) begin errors++; $display("FAIL show_first_valid: got %b want 1", out_valid); end
    wait_done(60, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL show_timeout: got no frame_done want one"); end
    checks++;
    if (population !== 5'd4) begin errors++; $display("FAIL show_pop: got %0d want 4", population); end
    checks++;
    if (gen_count !== gen_exp || en_cnt !== e0) begin errors++; $display("FAIL show_no_step: gen=%0d en=%0d want gen=%0d en=%0d", gen_count, en_cnt, gen_exp, e0); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.size() > 0 ? obs_q.pop_front() : 7'bx;
      checks++;
      if (o !== e) begin errors++; $display("FAIL show_rec: got %b want %b", o, e); end
    end
  endtask

  task automatic test_step();
    bit ok;
    logic [6:0] e, o;
    int e0 = en_cnt;
    alive_array = 16'hFFFF; prev_array = 16'h0050; out_ready = 1;
    step_req = 1;
    tick();
    step_req = 0;
    checks++;
    if (enable !== 1 || gen_count !== gen_exp) begin errors++; $display("FAIL step_pulse: en=%b gen=%0d want 1 %0d", enable, gen_count, gen_exp); end
    gen_exp++;
    tick();
    checks++;
    if (enable !== 0 || gen_count !== gen_exp) begin errors++; $display("FAIL step_gen: en=%b gen=%0d want 0 %0d", enable, gen_count, gen_exp); end
    alive_array = 16'h0070;
    push_frame();
    tick();
    checks++;
    if (out_valid !== 0) begin errors++; $display("FAIL step_capture_valid: got %b want 0", out_valid); end
    tick();
    checks++;
    if (out_valid !== 1) begin errors++; $display("FAIL step_first_valid: got %b want 1", out_valid); end
    alive_array = 16'hFFFF;
    wait_done(60, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL step_timeout: got no frame_done want one"); end
    checks++;
    if (population !== 5'd3 || en_cnt !== e0 + 1) begin errors++; $display("FAIL step_pop: pop=%0d en=%0d want 3 %0d", population, en_cnt, e0 + 1); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.size() > 0 ? obs_q.pop_front() : 7'bx;
      checks++;
      if (o !== e) begin errors++; $display("FAIL step_rec: got %b want %b", o, e); end
    end
  endtask

  task automatic test_backpressure();
    logic [6:0] e, o;
    int f0 = fd_cnt, e0 = en_cnt, c = 0;
    alive_array = 16'hA5C3; prev_array = 16'h3C5A; out_ready = 0;
    push_frame();
    show_req = 1;
    tick();
    show_req = 0;
    while (fd_cnt == f0 && c < 200) begin
      out_ready = (c % 2 == 0) ? ($urandom_range(0, 3) != 0) : 1'b0;
      step_req = c == 6;
      tick();
      c++;
    end
    step_req = 0;
    out_ready = 1;
    checks++;
    if (fd_cnt == f0) begin errors++; $display("FAIL bp_timeout: got no frame_done want one"); end
    checks++;
    if (population !== 5'($countones(16'hA5C3))) begin errors++; $display("FAIL bp_pop: got %0d want 8", population); end
    checks++;
    if (hold_viol !== 0) begin errors++; $display("FAIL bp_hold: got %0d unstable stalls want 0", hold_viol); end
    checks++;
    if (gen_count !== gen_exp || en_cnt !== e0) begin errors++; $display("FAIL bp_step_dropped: gen=%0d en=%0d want %0d %0d", gen_count, en_cnt, gen_exp, e0); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.size() > 0 ? obs_q.pop_front() : 7'bx;
      checks++;
      if (o !== e) begin errors++; $display("FAIL bp_rec: got %b want %b", o, e); end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL bp_extra: got %0d extra records want 0", obs_q.size()); end
  endtask

  task automatic test_priority();
    bit ok;
    logic [6:0] e, o;
    alive_array = 16'h8001; prev_array = 16'h0001; out_ready = 1;
    push_frame();
    show_req = 1; step_req = 1;
    tick();
    show_req = 0; step_req = 0;
    checks++;
    if (enable !== 1) begin errors++; $display("FAIL prio_enable: got %b want 1", enable); end
    gen_exp++;
    wait_done(60, ok);
    checks++;
    if (!ok || gen_count !== gen_exp || population !== 5'd2) begin
      errors++; $display("FAIL prio_done: ok=%b gen=%0d pop=%0d want 1 %0d 2", ok, gen_count, population, gen_exp);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.size() > 0 ? obs_q.pop_front() : 7'bx;
      checks++;
      if (o !== e) begin errors++; $display("FAIL prio_rec: got %b want %b", o, e); end
    end
  endtask

  task automatic test_free_run();
    bit ok, pend = 0;
    logic [6:0] e, o;
    int last = -1, gens = 0, cyc = 0, e0;
    alive_array = 16'h1234; prev_array = 16'h00FF; out_ready = 1;
    run = 1;
    while (gens < 70 && cyc < 3000) begin
      tick();
      cyc++;
      if (pend) begin
        checks++;
        if (gen_count !== gen_exp) begin errors++; $display("FAIL run_gen: got %0d want %0d", gen_count, gen_exp); end
        pend = 0;
      end
      if (enable) begin
        if (last >= 0) begin
          checks++;
          if (cyc - last != 20) begin errors++; $display("FAIL run_period: got %0d want 20", cyc - last); end
        end
        last = cyc;
        gen_exp++;
        pend = 1;
        gens++;
        push_frame();
      end
    end
    checks++;
    if (gens != 70) begin errors++; $display("FAIL run_timeout: got %0d generations want 70", gens); end
    repeat (8) tick();
    checks++;
    if (gen_count !== gen_exp || out_valid !== 1) begin errors++; $display("FAIL run_midscan: gen=%0d valid=%b want %0d 1", gen_count, out_valid, gen_exp); end
    run = 0;
    wait_done(60, ok);
    checks++;
    if (!ok || busy !== 0 || population !== 5'd5) begin
      errors++; $display("FAIL run_stop: ok=%b busy=%b pop=%0d want 1 0 5", ok, busy, population);
    end
    e0 = en_cnt;
    repeat (40) tick();
    checks++;
    if (en_cnt !== e0 || gen_count !== gen_exp) begin errors++; $display("FAIL run_idle: en=%0d gen=%0d want %0d %0d", en_cnt, gen_count, e0, gen_exp); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.size() > 0 ? obs_q.pop_front() : 7'bx;
      checks++;
      if (o !== e) begin errors++; $display("FAIL run_rec: got %b want %b", o, e); end
    end
  endtask

  task automatic test_reset_mid();
    int e0, f0;
    alive_array = 16'hFFFF; prev_array = 16'h0000; out_ready = 0;
    show_req = 1;
    tick();
    show_req = 0;
    repeat (3) tick();
    checks++;
    if (out_valid !== 1) begin errors++; $display("FAIL rst_pre: valid=%b want 1", out_valid); end
    reset = 1;
    repeat (2) tick();
    reset = 0;
    exp_q.delete();
    obs_q.delete();
    gen_exp = '0;
    checks++;
    if ({enable, out_valid, out_alive, out_changed, out_col, out_row, out_last, frame_done, busy, population, gen_count} !== '0) begin
      errors++; $display("FAIL rst_mid: got %b want all zero", {enable, out_valid, out_alive, out_changed, out_col, out_row, out_last, frame_done, busy, population, gen_count});
    end
    e0 = en_cnt; f0 = fd_cnt;
    out_ready = 1;
    repeat (30) tick();
    checks++;
    if (en_cnt !== e0 || fd_cnt !== f0 || busy !== 0) begin
      errors++; $display("FAIL rst_quiet: en=%0d fd=%0d busy=%b want %0d %0d 0", en_cnt, fd_cnt, busy, e0, f0);
    end
  endtask

  initial begin
    test_reset();
    test_show();
    test_step();
    test_backpressure();
    test_priority();
    test_free_run();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
